// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin dispatcher: default sizing and a
// one-hot to binary index helper.
package rr_pkg;

  localparam int unsigned NumOfAgentsDef = 4;
  localparam int unsigned IdxWidth       = $clog2(NumOfAgentsDef);
  localparam int unsigned MaxAgents      = 32;

  // Callers zero-extend their one-hot vector to MaxAgents bits.
  function automatic int unsigned onehot_to_idx(input logic [MaxAgents-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxAgents; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_dispatcher_if.sv
// Upstream handshake plus per-agent dispatch/credit signals of the dispatcher.
interface rr_dispatcher_if #(
  parameter int NumOfAgents = 4,
  parameter int DataWidth   = 8
);

  logic                   InValid;
  logic [DataWidth-1:0]   InData;
  logic                   InReady;
  logic [NumOfAgents-1:0] AgentEn;
  logic [NumOfAgents-1:0] CreditRet;
  logic [NumOfAgents-1:0] OutValid;
  logic [DataWidth-1:0]   OutData;
  logic                   CreditErr;

  modport master (
    output InValid, InData, AgentEn, CreditRet,
    input  InReady, OutValid, OutData, CreditErr
  );

  modport slave (
    input  InValid, InData, AgentEn, CreditRet,
    output InReady, OutValid, OutData, CreditErr
  );

endinterface

// File: rtl/priority_enc.sv
// Fixed-priority encoder: the lowest set request bit wins, result is one-hot.
module priority_enc #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] gnt_o,
  output logic             valid_o
);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin work distributor: sends each upstream transaction to the next
// enabled agent that still holds a buffer credit.
module rr_dispatcher
  import rr_pkg::*;
#(
  parameter int NumOfAgents = 4,
  parameter int DataWidth   = 8,
  parameter int CreditDepth = 2
) (
  input  logic            clk,
  input  logic            rst,
  rr_dispatcher_if.slave  bus
);

  localparam int IdxW = $clog2(NumOfAgents);
  localparam int CntW = $clog2(CreditDepth + 1);
  localparam logic [CntW-1:0] CreditFull = CntW'(CreditDepth);

  logic [CntW-1:0]        credit_q [NumOfAgents];
  logic [CntW-1:0]        credit_d [NumOfAgents];
  logic [IdxW-1:0]        last_q, last_d;
  logic [NumOfAgents-1:0] out_valid_q, out_valid_d;
  logic [DataWidth-1:0]   out_data_q, out_data_d;
  logic                   err_q, err_d;

  logic [NumOfAgents-1:0] elig, rot_req, rot_gnt, sel, dec;
  logic                   any_rot, accept;
  int unsigned            start;

  always_comb begin
    for (int i = 0; i < NumOfAgents; i++) begin
      elig[i] = bus.AgentEn[i] & (credit_q[i] != '0);
    end
  end

  assign bus.InReady = |elig;

  // Rotate so the agent after the last winner sits at bit 0, encode, rotate back.
  always_comb begin
    start   = (int'(last_q) == NumOfAgents - 1) ? 0 : int'(last_q) + 1;
    rot_req = '0;
    sel     = '0;
    for (int j = 0; j < NumOfAgents; j++) begin
      rot_req[j] = elig[(j + start) % NumOfAgents];
    end
    for (int j = 0; j < NumOfAgents; j++) begin
      if (rot_gnt[j]) sel[(j + start) % NumOfAgents] = 1'b1;
    end
  end

  priority_enc #(
    .Width (NumOfAgents)
  ) u_penc (
    .req_i   (rot_req),
    .gnt_o   (rot_gnt),
    .valid_o (any_rot)
  );

  assign accept = bus.InValid & any_rot;
  assign dec    = accept ? sel : '0;

  always_comb begin
    out_valid_d = dec;
    out_data_d  = accept ? bus.InData : out_data_q;
    last_d      = accept ? IdxW'(onehot_to_idx(MaxAgents'(sel))) : last_q;
    err_d       = err_q;
    for (int i = 0; i < NumOfAgents; i++) begin
      credit_d[i] = credit_q[i];
      if (dec[i] && !bus.CreditRet[i]) begin
        credit_d[i] = credit_q[i] - CntW'(1);
      end else if (bus.CreditRet[i] && !dec[i]) begin
        // A return into a full buffer is an agent protocol error; saturate.
        if (credit_q[i] == CreditFull) err_d = 1'b1;
        else                           credit_d[i] = credit_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumOfAgents; i++) credit_q[i] <= CreditFull;
      last_q      <= IdxW'(NumOfAgents - 1);
      out_valid_q <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NumOfAgents; i++) credit_q[i] <= credit_d[i];
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.OutValid  = out_valid_q;
  assign bus.OutData   = out_data_q;
  assign bus.CreditErr = err_q;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher with a per-cycle reference model of the
// round-robin/credit rules and hand-computed literal expectations.
module tb_rr_dispatcher;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int Depth = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   checkEn = 1'b0;

  always #5 clk = ~clk;

  rr_dispatcher_if #(.NumOfAgents(N), .DataWidth(DW)) bus ();

  rr_dispatcher #(
    .NumOfAgents (N),
    .DataWidth   (DW),
    .CreditDepth (Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model state
  int          mCredit [N];
  int          mLast;
  logic [N-1:0]  mOutValid;
  logic [DW-1:0] mOutData;
  logic        mErr;

  function automatic logic modelReady();
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.AgentEn[i] && mCredit[i] > 0) r = 1'b1;
    end
    return r;
  endfunction

  // Next agent is the first eligible one scanning forward from the last winner.
  always @(posedge clk) begin : model
    int target;
    bit acc;
    int d;
    if (rst) begin
      for (int i = 0; i < N; i++) mCredit[i] = Depth;
      mLast     = N - 1;
      mOutValid = '0;
      mOutData  = '0;
      mErr      = 1'b0;
    end else begin
      target = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (mLast + k) % N;
        if (target < 0 && bus.AgentEn[idx] && mCredit[idx] > 0) target = idx;
      end
      acc = bus.InValid && (target >= 0);
      if (acc) begin
        mOutValid = N'(1) << target;
        mOutData  = bus.InData;
        mLast     = target;
      end else begin
        mOutValid = '0;
      end
      for (int i = 0; i < N; i++) begin
        d = (acc && i == target) ? 1 : 0;
        if (bus.CreditRet[i] && d == 0 && mCredit[i] == Depth) mErr = 1'b1;
        else mCredit[i] = mCredit[i] - d + int'(bus.CreditRet[i]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("InReady",   32'(bus.InReady),   32'(modelReady()));
      checkOutput("OutValid",  32'(bus.OutValid),  32'(mOutValid));
      checkOutput("OutData",   32'(bus.OutData),   32'(mOutData));
      checkOutput("CreditErr", 32'(bus.CreditErr), 32'(mErr));
    end
  end

  // Drive inputs just after an edge, then return 1 time unit after the next edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic [N-1:0] en, input logic [N-1:0] ret);
    bus.InValid   = v;
    bus.InData    = d;
    bus.AgentEn   = en;
    bus.CreditRet = ret;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.InValid   = 1'b0;
    bus.InData    = '0;
    bus.AgentEn   = '0;
    bus.CreditRet = '0;

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'b1111, 4'b0000);
    applyStimulus(1'b0, 8'h00, 4'b1111, 4'b0000);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("rst_outvalid", 32'(bus.OutValid),  32'h0);
    checkOutput("rst_outdata",  32'(bus.OutData),   32'h0);
    checkOutput("rst_err",      32'(bus.CreditErr), 32'h0);
    checkOutput("rst_ready",    32'(bus.InReady),   32'h1);

    // Two full rounds consume every credit
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        applyStimulus(1'b1, DW'(8'h10 + r * 4 + i), 4'b1111, 4'b0000);
        checkOutput("rr_valid", 32'(bus.OutValid), 32'(1 << i));
        checkOutput("rr_data",  32'(bus.OutData),  32'(8'h10 + r * 4 + i));
      end
    end
    checkOutput("model_pin_last", 32'(mOutValid), 32'h8);

    applyStimulus(1'b1, 8'h18, 4'b1111, 4'b0000);
    checkOutput("dry_valid", 32'(bus.OutValid), 32'h0);
    checkOutput("dry_ready", 32'(bus.InReady),  32'h0);

    applyStimulus(1'b1, 8'h19, 4'b1111, 4'b0100);
    checkOutput("ret_same_cycle_valid", 32'(bus.OutValid), 32'h0);
    checkOutput("ret_next_ready",       32'(bus.InReady),  32'h1);
    applyStimulus(1'b1, 8'h20, 4'b1111, 4'b0000);
    checkOutput("ret_agent2_valid", 32'(bus.OutValid), 32'h4);
    checkOutput("ret_agent2_data",  32'(bus.OutData),  32'h20);
    checkOutput("model_pin_agent2", 32'(mOutValid),    32'h4);

    // Masked agents: only 1 and 3 may win
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'b1111, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, DW'(8'h30 + i), 4'b1010, 4'b0000);
      checkOutput("mask_valid", 32'(bus.OutValid), (i % 2 == 1) ? 32'h8 : 32'h2);
    end
    checkOutput("mask_ready", 32'(bus.InReady), 32'h0);

    // Dispatch and return on the same agent in the same cycle
    applyStimulus(1'b0, 8'h00, 4'b0010, 4'b0010);
    checkOutput("one_credit_ready", 32'(bus.InReady), 32'h1);
    applyStimulus(1'b1, 8'h40, 4'b0010, 4'b0010);
    checkOutput("dispret_valid", 32'(bus.OutValid), 32'h2);
    checkOutput("dispret_ready", 32'(bus.InReady),  32'h1);
    applyStimulus(1'b1, 8'h41, 4'b0010, 4'b0000);
    checkOutput("single_valid", 32'(bus.OutValid), 32'h2);
    checkOutput("single_ready", 32'(bus.InReady),  32'h0);

    // Overflow on agent 3
    applyStimulus(1'b0, 8'h00, 4'b1000, 4'b1000);
    applyStimulus(1'b0, 8'h00, 4'b1000, 4'b1000);
    checkOutput("refill_err", 32'(bus.CreditErr), 32'h0);
    applyStimulus(1'b0, 8'h00, 4'b1000, 4'b1000);
    checkOutput("ovf_err", 32'(bus.CreditErr), 32'h1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 4'b1000, 4'b0000);
      checkOutput("ovf_sticky", 32'(bus.CreditErr), 32'h1);
    end
    applyStimulus(1'b1, 8'h50, 4'b1000, 4'b0000);
    checkOutput("sat_valid0", 32'(bus.OutValid), 32'h8);
    applyStimulus(1'b1, 8'h51, 4'b1000, 4'b0000);
    checkOutput("sat_valid1", 32'(bus.OutValid), 32'h8);
    checkOutput("sat_ready",  32'(bus.InReady),  32'h0);

    // Mid-stream reset after three dispatches
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'b1111, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DW'(8'h60 + i), 4'b1111, 4'b0000);
      checkOutput("pre_rst_valid", 32'(bus.OutValid), 32'(1 << i));
    end
    rst = 1'b1;
    applyStimulus(1'b1, 8'h63, 4'b1111, 4'b0000);
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(bus.OutValid),  32'h0);
    checkOutput("midrst_err",   32'(bus.CreditErr), 32'h0);
    checkOutput("midrst_ready", 32'(bus.InReady),   32'h1);
    applyStimulus(1'b1, 8'h64, 4'b1111, 4'b0000);
    checkOutput("post_rst_first", 32'(bus.OutValid), 32'h1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, DW'(8'h65 + i), 4'b1111, 4'b0000);
      checkOutput("post_rst_seq", 32'(bus.OutValid), 32'(1 << ((i + 1) % 4)));
    end
    checkOutput("post_rst_drained", 32'(bus.InReady), 32'h0);

    applyStimulus(1'b0, 8'h00, 4'b1111, 4'b0000);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Round-robin work distributor: the inverse of the round-robin arbiter. One upstream valid/ready source fans out to NumOfAgents downstream consumers.
- Each consumer has a credit-based buffer. A transaction is sent only to an enabled agent that holds at least one credit; credits come back as per-agent return pulses.
- Sits between a shared request source and a bank of identical worker agents.

Parameters:
- NumOfAgents, 4, number of downstream agents (>=2)
- DataWidth, 8, payload width in bits
- CreditDepth, 2, per-agent buffer depth, i.e. initial credit count (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- InValid  input  1  upstream transaction valid
- InData  input  DataWidth  upstream payload
- InReady  output  1  dispatcher can accept this cycle
- AgentEn  input  NumOfAgents  per-agent enable mask; 0 excludes that agent from selection
- CreditRet  input  NumOfAgents  per-agent credit return pulse, one credit per cycle per bit
- OutValid  output  NumOfAgents  one-hot registered dispatch strobe
- OutData  output  DataWidth  registered payload, broadcast to all agents
- CreditErr  output  1  sticky overflow error flag

Behaviour:
- Reset (rst=1 at posedge):
  - Credit[i] = CreditDepth for all agents.
  - LastDisp = NumOfAgents-1, so the first dispatch goes to agent 0 when it is eligible.
  - OutValid = 0, OutData = 0, CreditErr = 0.
- rst has priority over all other inputs. A reset mid-operation discards in-flight credits and the current OutValid.
- Eligibility: Elig[i] = AgentEn[i] & (Credit[i] != 0).
- InReady = |Elig. It is combinational from state and AgentEn only, never from InValid.
- Selection: rotate Elig right by LastDisp+1, priority-encode with the lowest index winning, rotate back to get one-hot Sel. The search starts at LastDisp+1 and wraps modulo NumOfAgents.
- Accept occurs when InValid & InReady.
- On accept, at the next posedge:
  - OutValid <= Sel; OutData <= InData.
  - Credit[sel] decrements.
  - LastDisp <= index(Sel).
- Latency is exactly 1 cycle from accept to OutValid.
- OutValid is a single-cycle pulse. There is no downstream ready, because the credit guarantees space at the agent.
- No accept: OutValid <= 0, and OutData and LastDisp hold.
- Back-to-back accepts are allowed every cycle (throughput 1/cycle) while any agent is eligible.
- Credit update per agent each cycle: Credit[i] <= Credit[i] - dec[i] + CreditRet[i].
  - Simultaneous dispatch and return on the same agent leaves the count unchanged.
- Return while Credit[i]==CreditDepth with no dispatch to that agent that cycle:
  - Credit saturates at CreditDepth.
  - CreditErr <= 1 and stays set until reset.
- Credit counter width: $clog2(CreditDepth+1). All arithmetic is unsigned with no wrap.
- A return arriving in the same cycle cannot make that agent eligible in that cycle; it becomes eligible from the next cycle.
- AgentEn may change at any time.
  - A disabled agent keeps its credits and still accepts returns.
  - A dispatch already registered on OutValid is not cancelled.
- AgentEn = 0 or all credits exhausted: InReady = 0 and upstream stalls. LastDisp holds, so round-robin order resumes where it stopped.
- Single eligible agent: every accept goes to that agent until its credits run out.

Decomposition:
- Shared package (rr_pkg): a localparam for the index width, $clog2(NumOfAgents), and a helper function onehot_to_idx.
- Natural sub-module: reuse the codebase priority_enc (NumOfAgents) for the rotated selection.
- A per-agent credit counter generate block is kept inline and is not worth a separate module.

Test Plan:
- Reset, AgentEn=4'b1111, InValid held high with data 0x10,0x11,0x12,0x13, no returns. Required response:
  - OutValid sequence 0001,0010,0100,1000, each 1 cycle after accept.
  - OutData matches each accepted payload.
- Continue with no returns after 8 accepts (CreditDepth=2). Required response:
  - InReady=0 and OutValid=0.
  - Pulse CreditRet=4'b0100: the next accept goes to agent 2 only.
- AgentEn=4'b1010, 4 accepts. Required response: OutValid alternates 0010,1000,0010,1000, and agents 0 and 2 are never selected.
- Agent 1 at Credit=1, then dispatch to agent 1 together with CreditRet[1]=1 in the same cycle. Required response: Credit[1] stays 1, and agent 1 remains eligible the next cycle.
- CreditRet[3]=1 while Credit[3]=2 and no dispatch to agent 3. Required response: CreditErr=1 next cycle, sticky through 10 further cycles, and Credit[3] stays 2.
- Assert rst for 1 cycle mid-stream, after 3 dispatches. Required response:
  - OutValid=0 and all credits restored to 2.
  - The first post-reset dispatch goes to agent 0.
